pu_lut_sched: RTL and testbench

PU_LUT_SCHED -- requirements
Module: pu_lut_sched

---
 rtl/pu_lut_sched_if.sv | 55 +++++
 rtl/pu_lut_sched.sv | 103 ++++++++++
 tb/tb_pu_lut_sched.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pu_lut_sched_if.sv
// Handshake and LUT-bus bundle for pu_lut_sched.
// master: clients and the LUT; slave: the scheduler.
interface pu_lut_sched_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 1,
    parameter int SEL_WIDTH  = 2
);
    logic                  cfg_valid;
    logic [ADDR_WIDTH-1:0] cfg_addr;
    logic [DATA_WIDTH-1:0] cfg_data;
    logic                  cfg_ready;

    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [SEL_WIDTH-1:0]  req0_sel;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [SEL_WIDTH-1:0]  req1_sel;
    logic                  req1_ready;

    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_data;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_data;

    logic [ADDR_WIDTH-1:0] lut_addr;
    logic [SEL_WIDTH-1:0]  lut_sel;
    logic                  lut_signal_wr;
    logic                  lut_signal_oe;
    logic [DATA_WIDTH-1:0] lut_wdata;
    logic [DATA_WIDTH-1:0] lut_rdata;

    modport master (
        output cfg_valid, cfg_addr, cfg_data,
        output req0_valid, req0_addr, req0_sel,
        output req1_valid, req1_addr, req1_sel,
        output lut_rdata,
        input  cfg_ready, req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  lut_addr, lut_sel, lut_signal_wr,
        input  lut_signal_oe, lut_wdata
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data,
        input  req0_valid, req0_addr, req0_sel,
        input  req1_valid, req1_addr, req1_sel,
        input  lut_rdata,
        output cfg_ready, req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output lut_addr, lut_sel, lut_signal_wr,
        output lut_signal_oe, lut_wdata
    );
endinterface

// File: rtl/pu_lut_sched.sv
// LUT access scheduler: config writes beat two arbitrated read clients.
// Define PU_LUT_SCHED_ROUND_ROBIN_EN for round-robin, else client 0 wins.
module pu_lut_sched #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 1,
    parameter int SEL_WIDTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    pu_lut_sched_if.slave bus,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    state_t state;
    logic   gnt;
    logic   idle;
    logic   pick1;
    logic   grant0;
    logic   grant1;

`ifdef PU_LUT_SCHED_ROUND_ROBIN_EN
    logic last;
    // On a tie, serve whichever client was not granted last time.
    assign pick1 = bus.req0_valid && bus.req1_valid && !last;
`else
    assign pick1 = 1'b0;
`endif

    assign idle   = (state == IDLE) && !rst;
    assign busy   = (state != IDLE);
    assign grant0 = idle && !bus.cfg_valid
                  && bus.req0_valid && !pick1;
    assign grant1 = idle && !bus.cfg_valid && bus.req1_valid
                  && (!bus.req0_valid || pick1);

    assign bus.cfg_ready  = idle && bus.cfg_valid;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            gnt               <= 1'b0;
            bus.lut_signal_wr <= 1'b0;
            bus.lut_signal_oe <= 1'b0;
            bus.lut_addr      <= '0;
            bus.lut_sel       <= '0;
            bus.lut_wdata     <= '0;
            bus.rsp0_valid    <= 1'b0;
            bus.rsp0_data     <= '0;
            bus.rsp1_valid    <= 1'b0;
            bus.rsp1_data     <= '0;
`ifdef PU_LUT_SCHED_ROUND_ROBIN_EN
            last              <= 1'b1;
`endif
        end else begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cfg_ready) begin
                        state             <= WRITE;
                        bus.lut_signal_wr <= 1'b1;
                        bus.lut_addr      <= bus.cfg_addr;
                        bus.lut_wdata     <= bus.cfg_data;
                    end else if (grant0 || grant1) begin
                        state             <= READ;
                        gnt               <= grant1;
                        bus.lut_signal_oe <= 1'b1;
                        bus.lut_addr      <= grant1 ? bus.req1_addr
                                                    : bus.req0_addr;
                        bus.lut_sel       <= grant1 ? bus.req1_sel
                                                    : bus.req0_sel;
`ifdef PU_LUT_SCHED_ROUND_ROBIN_EN
                        last              <= grant1;
`endif
                    end
                end
                WRITE: begin
                    state             <= IDLE;
                    bus.lut_signal_wr <= 1'b0;
                end
                READ: begin
                    state             <= IDLE;
                    bus.lut_signal_oe <= 1'b0;
                    if (gnt) begin
                        bus.rsp1_valid <= 1'b1;
                        bus.rsp1_data  <= bus.lut_rdata;
                    end else begin
                        bus.rsp0_valid <= 1'b1;
                        bus.rsp0_data  <= bus.lut_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pu_lut_sched.sv
// Testbench for pu_lut_sched: directed steps plus random traffic
// checked against a transaction-level LUT/arbiter model.
module tb_pu_lut_sched;
`ifdef PU_LUT_SCHED_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   n_tests = 0;
    int   n_fail = 0;

    pu_lut_sched_if bus ();

    pu_lut_sched dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // LUT device: garbage (inverted) data outside the oe cycle
    logic lut_mem [16];
    always @(posedge clk)
        if (bus.lut_signal_wr) lut_mem[bus.lut_addr] <= bus.lut_wdata;
    assign bus.lut_rdata = bus.lut_signal_oe ? lut_mem[bus.lut_addr]
                                             : ~lut_mem[bus.lut_addr];

    logic exp_mem [16];
    logic exp_rsp [2];
    bit   exp_last;
    logic [3:0] exp_la;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic prv0 = 1'b0;
    logic prv1 = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            n_tests++;
            assert (!(bus.lut_signal_wr && bus.lut_signal_oe)) else begin
                n_fail++;
                $error("FAIL wr_oe_overlap: got 1 expected 0");
            end
            n_tests++;
            assert (!((bus.rsp0_valid && prv0) || (bus.rsp1_valid && prv1)))
            else begin
                n_fail++;
                $error("FAIL rsp_len: got 2 cycles expected 1");
            end
        end
        prv0 = bus.rsp0_valid;
        prv1 = bus.rsp1_valid;
    end

    task automatic idle_inputs();
        bus.cfg_valid  = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cfg_valid  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #2;
        chk("rst_ready", 32'({bus.cfg_ready, bus.req0_ready,
                              bus.req1_ready}), 32'd0);
        tick();
        tick();
        chk("rst_lut", 32'({bus.lut_signal_wr, bus.lut_signal_oe,
                            bus.lut_addr, bus.lut_sel, bus.lut_wdata}), 32'd0);
        chk("rst_rsp", 32'({bus.rsp0_valid, bus.rsp0_data,
                            bus.rsp1_valid, bus.rsp1_data}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle_inputs();
        exp_last = 1'b1;
        exp_rsp[0] = 1'b0;
        exp_rsp[1] = 1'b0;
        exp_la = 4'd0;
    endtask

    // Present any mix of cfg/req0/req1 and serve every one of them.
    task automatic transact(input bit cv, input logic [3:0] ca,
                            input logic cd,
                            input bit v0, input logic [3:0] a0,
                            input logic [1:0] s0,
                            input bit v1, input logic [3:0] a1,
                            input logic [1:0] s1);
        bit pc, p0, p1, w, rd;
        logic [3:0] ra;
        logic [1:0] rs;
        logic [2:0] er;
        pc = cv; p0 = v0; p1 = v1;
        w = 1'b0;
        bus.cfg_valid = cv;  bus.cfg_addr = ca;  bus.cfg_data = cd;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_sel = s0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_sel = s1;
        while (pc || p0 || p1) begin
            #2;
            rd = !pc;
            if (pc) er = 3'b100;
            else begin
                w = (p0 && p1) ? (RR ? !exp_last : 1'b0) : p1;
                er = w ? 3'b001 : 3'b010;
            end
            chk("ready", 32'({bus.cfg_ready, bus.req0_ready,
                              bus.req1_ready}), 32'(er));
            tick();
            if (!rd) begin
                pc = 1'b0;
                bus.cfg_valid = 1'b0;
                exp_mem[ca] = cd;
                exp_la = ca;
                chk("wr_cycle", 32'({bus.lut_signal_wr, bus.lut_signal_oe}),
                    32'b10);
                chk("wr_addr", 32'(bus.lut_addr), 32'(ca));
                chk("wr_data", 32'(bus.lut_wdata), 32'(cd));
            end else begin
                if (w) begin
                    p1 = 1'b0; bus.req1_valid = 1'b0; ra = a1; rs = s1;
                end else begin
                    p0 = 1'b0; bus.req0_valid = 1'b0; ra = a0; rs = s0;
                end
                exp_last = w;
                exp_la = ra;
                chk("rd_cycle", 32'({bus.lut_signal_wr, bus.lut_signal_oe}),
                    32'b01);
                chk("rd_addr", 32'(bus.lut_addr), 32'(ra));
                chk("rd_sel", 32'(bus.lut_sel), 32'(rs));
            end
            chk("op_busy", 32'(busy), 32'd1);
            chk("op_ready", 32'({bus.cfg_ready, bus.req0_ready,
                                 bus.req1_ready}), 32'd0);
            chk("op_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
            tick();
            chk("post_strobes", 32'({busy, bus.lut_signal_wr,
                                     bus.lut_signal_oe}), 32'd0);
            chk("post_addr_hold", 32'(bus.lut_addr), 32'(exp_la));
            if (rd) exp_rsp[w] = exp_mem[ra];
            chk("rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}),
                rd ? (w ? 32'b01 : 32'b10) : 32'b00);
            chk("rsp0_data", 32'(bus.rsp0_data), 32'(exp_rsp[0]));
            chk("rsp1_data", 32'(bus.rsp1_data), 32'(exp_rsp[1]));
        end
    endtask

    initial begin
        bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.req0_addr = '0; bus.req0_sel = '0;
        bus.req1_addr = '0; bus.req1_sel = '0;
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            lut_mem[i] = 1'b0;
            exp_mem[i] = 1'b0;
        end
        do_reset();

        transact(1, 4'd5, 1'b1, 0, 4'd0, 2'd0, 0, 4'd0, 2'd0);

        for (int i = 0; i < 16; i++)
            transact(1, 4'(i), i[0], 0, 4'd0, 2'd0, 0, 4'd0, 2'd0);
        for (int i = 0; i < 16; i++)
            transact(0, 4'd0, 1'b0, 1, 4'(i), 2'd2, 0, 4'd0, 2'd0);

        transact(1, 4'd3, ~exp_mem[3], 1, 4'd3, 2'd1, 0, 4'd0, 2'd0);
        transact(1, 4'd8, ~exp_mem[8], 1, 4'd8, 2'd3, 1, 4'd8, 2'd2);

        // Both clients keep requesting across six grants
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd2; bus.req0_sel = 2'd1;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd9; bus.req1_sel = 2'd3;
        for (int i = 0; i < 6; i++) begin
            bit w;
            logic [3:0] ra;
            #2;
            w = RR ? !exp_last : 1'b0;
            ra = w ? 4'd9 : 4'd2;
            chk("hold_grant", 32'({bus.req0_ready, bus.req1_ready}),
                w ? 32'b01 : 32'b10);
            tick();
            exp_last = w;
            chk("hold_addr", 32'(bus.lut_addr), 32'(ra));
            tick();
            exp_rsp[w] = exp_mem[ra];
            chk("hold_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid}),
                w ? 32'b01 : 32'b10);
            chk("hold_data", 32'(w ? bus.rsp1_data : bus.rsp0_data),
                32'(exp_rsp[w]));
        end
        idle_inputs();
        tick();

        // Reset while client 1's read is in flight
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd7; bus.req1_sel = 2'd2;
        #2;
        chk("abort_grant", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        chk("abort_oe", 32'(bus.lut_signal_oe), 32'd1);
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        #2;
        chk("abort_ready", 32'({bus.cfg_ready, bus.req0_ready,
                                bus.req1_ready}), 32'd0);
        tick();
        rst = 1'b0;
        idle_inputs();
        chk("abort_lut", 32'({bus.lut_signal_wr, bus.lut_signal_oe,
                              bus.lut_addr, bus.lut_sel, bus.lut_wdata}),
            32'd0);
        chk("abort_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid,
                              bus.rsp0_data, bus.rsp1_data}), 32'd0);
        tick();
        chk("abort_no_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        exp_last = 1'b1;
        exp_rsp[0] = 1'b0;
        exp_rsp[1] = 1'b0;
        exp_la = 4'd0;
        transact(0, 4'd0, 1'b0, 1, 4'd4, 2'd1, 1, 4'd11, 2'd0);

        for (int n = 0; n < 40; n++) begin
            bit cv, v0, v1;
            cv = ($urandom_range(0, 3) == 0);
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!cv && !v0 && !v1) v1 = 1'b1;
            transact(cv, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     v0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                     v1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
